// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one zero-latency data-memory port between the core's
// load/store interface (master 0, fixed priority) and a debug/loader port
// (master 1, protected by a saturating starvation counter). Either master can
// lock the port for back-to-back accesses. Grants are combinational from the
// registered arbitration state so a granted access completes in its cycle.
//
// Optional feature: define DMEM_ARB_STATS_EN to build the grant/conflict
// statistics counters and their gnt_cnt0/gnt_cnt1/conflict_cnt ports.
`timescale 1ns/1ps

module dmem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    // master 0: core load/store port
    input  logic                    m0_req,
    input  logic                    m0_lock,
    input  logic [ADDR_WIDTH-1:0]   m0_addr,
    input  logic [DATA_WIDTH-1:0]   m0_wdata,
    input  logic [DATA_WIDTH/8-1:0] m0_wstrb,
    input  logic                    m0_write,
    output logic                    m0_gnt,
    output logic [DATA_WIDTH-1:0]   m0_rdata,
    // master 1: debug/loader port
    input  logic                    m1_req,
    input  logic                    m1_lock,
    input  logic [ADDR_WIDTH-1:0]   m1_addr,
    input  logic [DATA_WIDTH-1:0]   m1_wdata,
    input  logic [DATA_WIDTH/8-1:0] m1_wstrb,
    input  logic                    m1_write,
    output logic                    m1_gnt,
    output logic [DATA_WIDTH-1:0]   m1_rdata,
    // memory side
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    output logic [DATA_WIDTH/8-1:0] mem_wstrb,
    output logic                    mem_write,
    output logic                    mem_read,
    input  logic [DATA_WIDTH-1:0]   mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [31:0]             gnt_cnt0,
    output logic [31:0]             gnt_cnt1,
    output logic [31:0]             conflict_cnt
`endif
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    typedef enum logic [1:0] {
        FREE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } st_t;

    st_t               st;
    logic [WAIT_W-1:0] wait_cnt;
    logic              force1;
    logic              g0;
    logic              g1;

    // Saturating increment of the starvation counter; holds at MAX_WAIT.
    function automatic logic [WAIT_W-1:0] wait_sat_inc(input logic [WAIT_W-1:0] v);
        if (v == WAIT_MAX) begin
            return v;
        end
        return v + WAIT_W'(1);
    endfunction

    // Master 1 has waited its full budget: it wins regardless of any lock.
    assign force1 = m1_req && (wait_cnt == WAIT_MAX);

    // Grant selection from the registered state; reset forces no grant at once.
    always_comb begin
        g0 = 1'b0;
        g1 = 1'b0;
        if (!rst) begin
            if (force1) begin
                g1 = 1'b1;
            end else begin
                case (st)
                    LOCK0:   g0 = m0_req;
                    LOCK1:   g1 = m1_req;
                    default: begin
                        if (m0_req) begin
                            g0 = 1'b1;
                        end else if (m1_req) begin
                            g1 = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign m0_gnt = g0;
    assign m1_gnt = g1;

    // Read data is shared; each master qualifies it with its own grant.
    assign m0_rdata = mem_rdata;
    assign m1_rdata = mem_rdata;

    // Steer the granted master onto the memory port; idle port is all zero.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_wstrb = {STRB_W{1'b0}};
        mem_write = 1'b0;
        mem_read  = 1'b0;
        if (g0) begin
            mem_addr  = m0_addr;
            mem_wdata = m0_wdata;
            mem_wstrb = m0_wstrb;
            mem_write = m0_write;
            mem_read  = ~m0_write;
        end else if (g1) begin
            mem_addr  = m1_addr;
            mem_wdata = m1_wdata;
            mem_wstrb = m1_wstrb;
            mem_write = m1_write;
            mem_read  = ~m1_write;
        end
    end

    // Ownership state: a granted master keeps the port only while it asks to
    // lock; an ungranted cycle (idle, or locked owner not requesting) frees it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st <= FREE;
        end else if (g0) begin
            st <= m0_lock ? LOCK0 : FREE;
        end else if (g1) begin
            st <= m1_lock ? LOCK1 : FREE;
        end else begin
            st <= FREE;
        end
    end

    // Starvation counter: counts cycles master 1 requests without a grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (g1 || !m1_req) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_sat_inc(wait_cnt);
        end
    end

`ifdef DMEM_ARB_STATS_EN
    // Free-running statistics: grants per master and cycles with contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gnt_cnt0     <= 32'd0;
            gnt_cnt1     <= 32'd0;
            conflict_cnt <= 32'd0;
        end else begin
            if (g0) begin
                gnt_cnt0 <= gnt_cnt0 + 32'd1;
            end
            if (g1) begin
                gnt_cnt1 <= gnt_cnt1 + 32'd1;
            end
            if (m0_req && m1_req) begin
                conflict_cnt <= conflict_cnt + 32'd1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench for dmem_arbiter with a small zero-latency
// memory model. Expected grants are queued per scenario and popped each cycle.
`timescale 1ns/1ps

module tb_dmem_arbiter;

    logic        clk;
    logic        rst;
    logic        m0_req, m0_lock, m0_write;
    logic [31:0] m0_addr, m0_wdata;
    logic [3:0]  m0_wstrb;
    logic        m0_gnt;
    logic [31:0] m0_rdata;
    logic        m1_req, m1_lock, m1_write;
    logic [31:0] m1_addr, m1_wdata;
    logic [3:0]  m1_wstrb;
    logic        m1_gnt;
    logic [31:0] m1_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;
    logic        mem_write, mem_read;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] gnt_cnt0, gnt_cnt1, conflict_cnt;
`endif

    int total;
    int bad;
    int cyc;

    typedef struct {
        logic        g0;
        logic        g1;
        logic        rd_chk;
        logic [31:0] rd_val;
    } exp_t;

    exp_t sb[$];

    logic [31:0] mem [0:63];

    dmem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_WAIT(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .m0_req    (m0_req),
        .m0_lock   (m0_lock),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_wstrb  (m0_wstrb),
        .m0_write  (m0_write),
        .m0_gnt    (m0_gnt),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_lock   (m1_lock),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_wstrb  (m1_wstrb),
        .m1_write  (m1_write),
        .m1_gnt    (m1_gnt),
        .m1_rdata  (m1_rdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_write (mem_write),
        .mem_read  (mem_read),
        .mem_rdata (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .gnt_cnt0     (gnt_cnt0),
        .gnt_cnt1     (gnt_cnt1),
        .conflict_cnt (conflict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // zero-latency memory: combinational read, byte-strobed write on the edge
    assign mem_rdata = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'd0;
            mem[4] <= 32'h1111_2222;
        end else if (mem_write) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic push(input logic g0, input logic g1);
        exp_t e;
        e.g0 = g0; e.g1 = g1; e.rd_chk = 1'b0; e.rd_val = 32'd0;
        sb.push_back(e);
    endtask

    task automatic push_rd(input logic g0, input logic g1, input logic [31:0] v);
        exp_t e;
        e.g0 = g0; e.g1 = g1; e.rd_chk = 1'b1; e.rd_val = v;
        sb.push_back(e);
    endtask

    // One clock: sample at the falling edge, check against the next expectation.
    task automatic step();
        exp_t        e;
        logic [31:0] ea, ewd;
        logic [3:0]  es;
        logic        ew, er;
        @(negedge clk);
        if (sb.size() == 0) begin
            chk("sb_underflow", 64'd1, 64'd0);
        end else begin
            e = sb.pop_front();
            chk("m0_gnt", {63'd0, m0_gnt}, {63'd0, e.g0});
            chk("m1_gnt", {63'd0, m1_gnt}, {63'd0, e.g1});
            ea = 32'd0; ewd = 32'd0; es = 4'd0; ew = 1'b0; er = 1'b0;
            if (e.g0) begin
                ea = m0_addr; ewd = m0_wdata; es = m0_wstrb; ew = m0_write; er = !m0_write;
            end else if (e.g1) begin
                ea = m1_addr; ewd = m1_wdata; es = m1_wstrb; ew = m1_write; er = !m1_write;
            end
            chk("mem_addr",  {32'd0, mem_addr},  {32'd0, ea});
            chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, ewd});
            chk("mem_wstrb", {60'd0, mem_wstrb}, {60'd0, es});
            chk("mem_write", {63'd0, mem_write}, {63'd0, ew});
            chk("mem_read",  {63'd0, mem_read},  {63'd0, er});
            if (e.rd_chk && e.g0) chk("m0_rdata", {32'd0, m0_rdata}, {32'd0, e.rd_val});
            if (e.rd_chk && e.g1) chk("m1_rdata", {32'd0, m1_rdata}, {32'd0, e.rd_val});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0; cyc = 0;
        rst = 1'b1;
        m0_req = 0; m0_lock = 0; m0_write = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_req = 0; m1_lock = 0; m1_write = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        repeat (3) @(posedge clk);
        #1;

        // requests during reset must not be granted
        m0_req = 1; m0_addr = 32'h10; m1_req = 1; m1_addr = 32'h20;
        #1;
        chk("rst_m0_gnt", {63'd0, m0_gnt}, 64'd0);
        chk("rst_m1_gnt", {63'd0, m1_gnt}, 64'd0);
        chk("rst_mem_read", {63'd0, mem_read}, 64'd0);
        chk("rst_mem_addr", {32'd0, mem_addr}, 64'd0);
        m0_req = 0; m1_req = 0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;

        // idle: ten cycles with no requests
        repeat (10) push(1'b0, 1'b0);
        repeat (10) step();

        // contention: m0 reads 0x10, m1 writes 0xdeadbeef to 0x20
        m0_req = 1; m0_write = 0; m0_addr = 32'h10;
        m1_req = 1; m1_write = 1; m1_addr = 32'h20; m1_wdata = 32'hdead_beef; m1_wstrb = 4'hf;
        for (int i = 0; i < 10; i++) begin
            if (i == 8) push(1'b0, 1'b1);
            else        push_rd(1'b1, 1'b0, 32'h1111_2222);
        end
        repeat (10) step();
`ifdef DMEM_ARB_STATS_EN
        chk("gnt_cnt0", {32'd0, gnt_cnt0}, 64'd9);
        chk("gnt_cnt1", {32'd0, gnt_cnt1}, 64'd1);
        chk("conflict_cnt", {32'd0, conflict_cnt}, 64'd10);
`endif
        m0_req = 0;
        m1_write = 0;
        push_rd(1'b0, 1'b1, 32'hdead_beef);
        step();
        m1_req = 0;

        // m1 locks for three writes, unlocks on the fourth; m0 waits meanwhile
        m1_req = 1; m1_lock = 1; m1_write = 1; m1_wstrb = 4'hf;
        m1_addr = 32'h30; m1_wdata = 32'ha0; push(1'b0, 1'b1); step();
        m0_req = 1; m0_write = 0; m0_addr = 32'h40;
        m1_addr = 32'h34; m1_wdata = 32'ha1; push(1'b0, 1'b1); step();
        m1_addr = 32'h38; m1_wdata = 32'ha2; push(1'b0, 1'b1); step();
        m1_lock = 0;
        m1_addr = 32'h3c; m1_wdata = 32'ha3; push(1'b0, 1'b1); step();
        m1_req = 0;
        push_rd(1'b1, 1'b0, 32'd0); step();
        m0_addr = 32'h34;
        push_rd(1'b1, 1'b0, 32'ha1); step();
        m0_req = 0;

        // m0 holds a lock; m1 is force-granted on its ninth waiting cycle
        m0_req = 1; m0_lock = 1; m0_addr = 32'h10;
        m1_write = 0; m1_addr = 32'h30; m1_lock = 0;
        push(1'b1, 1'b0); step();
        m1_req = 1;
        for (int i = 0; i < 9; i++) begin
            if (i == 8) push_rd(1'b0, 1'b1, 32'ha0);
            else        push_rd(1'b1, 1'b0, 32'h1111_2222);
        end
        repeat (9) step();
        m1_req = 0;
        push(1'b1, 1'b0); step();
        // locked owner not requesting blocks m1 for one cycle, then frees
        m0_req = 0; m1_req = 1;
        push(1'b0, 1'b0); step();
        push_rd(1'b0, 1'b1, 32'ha0); step();
        m1_req = 0; m0_lock = 0;

        // async reset in the middle of a LOCK0 cycle
        m0_req = 1; m0_lock = 1; m0_addr = 32'h10;
        push(1'b1, 1'b0); step();
        chk("lock_pre_rst", {63'd0, m0_gnt}, 64'd1);
        rst = 1'b1;
        #1;
        chk("async_m0_gnt", {63'd0, m0_gnt}, 64'd0);
        chk("async_mem_read", {63'd0, mem_read}, 64'd0);
        chk("async_mem_addr", {32'd0, mem_addr}, 64'd0);
        rst = 1'b0;
`ifdef DMEM_ARB_STATS_EN
        chk("rst_gnt_cnt0", {32'd0, gnt_cnt0}, 64'd0);
`endif
        m0_req = 0; m0_lock = 0;
        m1_req = 1; m1_addr = 32'h20; m1_write = 0;
        push_rd(1'b0, 1'b1, 32'hdead_beef); step();
        push_rd(1'b0, 1'b1, 32'hdead_beef); step();
        m1_req = 0;

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
